// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation codes and sequencer state type shared with the ALU decoder
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_XOR  = 4'b1001;
   localparam logic [3:0] ALU_PASS = 4'b1111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } alu_state_t;

   function automatic logic is_shift_op(input logic [3:0] code);
      return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// rtl/alu_serial_shifter.sv - bit-serial shifter, one bit position per cycle
module alu_serial_shifter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             dir_left,
   input  logic             arith,
   input  logic [4:0]       amount,
   input  logic [WIDTH-1:0] load_value,
   output logic             done,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] val_q;
   logic [4:0]       cnt_q;
   logic             left_q;
   logic             arith_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         val_q   <= '0;
         cnt_q   <= '0;
         left_q  <= 1'b0;
         arith_q <= 1'b0;
      end else if (load) begin
         val_q   <= load_value;
         cnt_q   <= amount;
         left_q  <= dir_left;
         arith_q <= arith;
      end else if (cnt_q != 5'd0) begin
         cnt_q <= cnt_q - 5'd1;
         // the MSB never changes during an arithmetic shift, so it keeps the captured sign
         if (left_q)
            val_q <= {val_q[WIDTH-2:0], 1'b0};
         else
            val_q <= {arith_q & val_q[WIDTH-1], val_q[WIDTH-1:1]};
      end
   end

   // asserted during the cycle whose closing edge performs the final shift
   assign done  = (cnt_q == 5'd1);
   assign value = val_q;

endmodule

// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - sequenced ALU with valid/ready handshake and serial shifts
module alu_seq_exec
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             illegal
);

   alu_state_t       state, state_n;
   logic [WIDTH-1:0] res_q;
   logic             illegal_q;
   logic             from_shifter_q;
   logic [WIDTH-1:0] alu_res;
   logic             illegal_c;
   logic             accept;
   logic             shift_load;
   logic             sh_done;
   logic [WIDTH-1:0] sh_value;

   // single-cycle result; zero-amount shifts collapse to SrcA here
   always_comb begin
      alu_res   = '0;
      illegal_c = 1'b0;
      case (ALUControl)
         ALU_ADD:  alu_res = SrcA + SrcB;
         ALU_SUB:  alu_res = SrcA - SrcB;
         ALU_AND:  alu_res = SrcA & SrcB;
         ALU_OR:   alu_res = SrcA | SrcB;
         ALU_XOR:  alu_res = SrcA ^ SrcB;
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
         ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
         ALU_PASS: alu_res = SrcB;
         ALU_SLL, ALU_SRL, ALU_SRA: alu_res = SrcA;
         default:  illegal_c = 1'b1;
      endcase
   end

   always_comb begin
      state_n    = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      shift_load = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept = 1'b1;
               if (is_shift_op(ALUControl) && (SrcB[4:0] != 5'd0)) begin
                  shift_load = 1'b1;
                  state_n    = SHIFT;
               end else begin
                  state_n = DONE;
               end
            end
         end
         SHIFT: begin
            if (sh_done)
               state_n = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         res_q          <= '0;
         illegal_q      <= 1'b0;
         from_shifter_q <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            res_q          <= alu_res;
            illegal_q      <= illegal_c;
            from_shifter_q <= shift_load;
         end
      end
   end

   alu_serial_shifter #(.WIDTH(WIDTH)) u_shifter (
      .clk        (clk),
      .reset      (reset),
      .load       (shift_load),
      .dir_left   (ALUControl == ALU_SLL),
      .arith      (ALUControl == ALU_SRA),
      .amount     (SrcB[4:0]),
      .load_value (SrcA),
      .done       (sh_done),
      .value      (sh_value)
   );

   // shifter holds its value once its count reaches zero, so it can drive the result directly
   assign ALUResult = from_shifter_q ? sh_value : res_q;
   assign Zero      = out_valid & (ALUResult == '0);
   assign illegal   = out_valid & illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - directed self-checking bench for alu_seq_exec
module tb_alu_seq_exec;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       ALUControl;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] ALUResult;
   logic             Zero;
   logic             illegal;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   alu_seq_exec #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ALUControl (ALUControl),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ALUResult  (ALUResult),
      .Zero       (Zero),
      .illegal    (illegal)
   );

   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      ALUControl = c;
      SrcA       = a;
      SrcB       = b;
      in_valid   = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // latency counts negedges after the accepting edge; bounded at 200
   task automatic wait_valid(output int lat, output bit rdy_low);
      lat     = 0;
      rdy_low = 1'b1;
      while (lat < 200) begin
         @(negedge clk);
         lat++;
         if (in_ready) rdy_low = 1'b0;
         if (out_valid) break;
      end
   endtask

   task automatic pop;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else pass_cnt++;
      total_cnt++; if (ALUResult !== 32'h0) $display("FAIL rst_result: got %h expected 00000000", ALUResult); else pass_cnt++;
      total_cnt++; if (Zero !== 1'b0) $display("FAIL rst_zero: got %b expected 0", Zero); else pass_cnt++;
      total_cnt++; if (illegal !== 1'b0) $display("FAIL rst_illegal: got %b expected 0", illegal); else pass_cnt++;
      reset = 1'b1;
      @(negedge clk);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_add;
      int lat; bit rl;
      issue(4'b0000, 32'h7FFF_FFFF, 32'h1);
      wait_valid(lat, rl);
      total_cnt++; if (ALUResult !== 32'h8000_0000) $display("FAIL add_result: got %h expected 80000000", ALUResult); else pass_cnt++;
      total_cnt++; if (Zero !== 1'b0) $display("FAIL add_zero: got %b expected 0", Zero); else pass_cnt++;
      total_cnt++; if (lat != 1) $display("FAIL add_latency: got %0d expected 1", lat); else pass_cnt++;
      total_cnt++; if (illegal !== 1'b0) $display("FAIL add_illegal: got %b expected 0", illegal); else pass_cnt++;
      pop();
   endtask

   task automatic test_sub_slt;
      int lat; bit rl;
      issue(4'b0001, 32'd5, 32'd5);
      wait_valid(lat, rl);
      total_cnt++; if (ALUResult !== 32'h0) $display("FAIL sub_result: got %h expected 00000000", ALUResult); else pass_cnt++;
      total_cnt++; if (Zero !== 1'b1) $display("FAIL sub_zero: got %b expected 1", Zero); else pass_cnt++;
      pop();
      issue(4'b0101, 32'hFFFF_FFFF, 32'h1);
      wait_valid(lat, rl);
      total_cnt++; if (ALUResult !== 32'h1) $display("FAIL slt_result: got %h expected 00000001", ALUResult); else pass_cnt++;
      total_cnt++; if (Zero !== 1'b0) $display("FAIL slt_zero: got %b expected 0", Zero); else pass_cnt++;
      pop();
      issue(4'b1000, 32'hFFFF_FFFF, 32'h1);
      wait_valid(lat, rl);
      total_cnt++; if (ALUResult !== 32'h0) $display("FAIL sltu_result: got %h expected 00000000", ALUResult); else pass_cnt++;
      total_cnt++; if (Zero !== 1'b1) $display("FAIL sltu_zero: got %b expected 1", Zero); else pass_cnt++;
      pop();
   endtask

   task automatic test_shifts;
      int lat; bit rl;
      issue(4'b0110, 32'h8000_0000, 32'd31);
      wait_valid(lat, rl);
      total_cnt++; if (ALUResult !== 32'hFFFF_FFFF) $display("FAIL sra_result: got %h expected ffffffff", ALUResult); else pass_cnt++;
      total_cnt++; if (lat != 32) $display("FAIL sra_latency: got %0d expected 32", lat); else pass_cnt++;
      total_cnt++; if (rl !== 1'b1) $display("FAIL sra_in_ready_low: got %b expected 1", rl); else pass_cnt++;
      pop();
      issue(4'b0111, 32'h8000_0000, 32'd31);
      wait_valid(lat, rl);
      total_cnt++; if (ALUResult !== 32'h1) $display("FAIL srl_result: got %h expected 00000001", ALUResult); else pass_cnt++;
      total_cnt++; if (lat != 32) $display("FAIL srl_latency: got %0d expected 32", lat); else pass_cnt++;
      pop();
      issue(4'b0100, 32'hDEAD_BEEF, 32'h0);
      wait_valid(lat, rl);
      total_cnt++; if (ALUResult !== 32'hDEAD_BEEF) $display("FAIL sll0_result: got %h expected deadbeef", ALUResult); else pass_cnt++;
      total_cnt++; if (lat != 1) $display("FAIL sll0_latency: got %0d expected 1", lat); else pass_cnt++;
      pop();
      issue(4'b0110, 32'h4000_0010, 32'd4);
      wait_valid(lat, rl);
      total_cnt++; if (ALUResult !== 32'h0400_0001) $display("FAIL sra_pos_result: got %h expected 04000001", ALUResult); else pass_cnt++;
      total_cnt++; if (lat != 5) $display("FAIL sra_pos_latency: got %0d expected 5", lat); else pass_cnt++;
      pop();
   endtask

   task automatic test_ignore_inputs;
      int lat; bit rl;
      issue(4'b0100, 32'h3, 32'd3);
      in_valid   = 1'b1;
      ALUControl = 4'b0000;
      SrcA       = 32'hFFFF;
      SrcB       = 32'h1;
      wait_valid(lat, rl);
      in_valid = 1'b0;
      total_cnt++; if (ALUResult !== 32'h18) $display("FAIL ignore_result: got %h expected 00000018", ALUResult); else pass_cnt++;
      total_cnt++; if (lat != 4) $display("FAIL ignore_latency: got %0d expected 4", lat); else pass_cnt++;
      pop();
   endtask

   task automatic test_backpressure;
      int lat; bit rl; bit stable;
      logic [31:0] r;
      issue(4'b1001, 32'h0000_F0F0, 32'h0000_0FF0);
      wait_valid(lat, rl);
      r      = ALUResult;
      stable = 1'b1;
      total_cnt++; if (r !== 32'h0000_FF00) $display("FAIL bp_result: got %h expected 0000ff00", r); else pass_cnt++;
      repeat (5) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || ALUResult !== 32'h0000_FF00 || Zero !== 1'b0 || in_ready !== 1'b0)
            stable = 1'b0;
      end
      total_cnt++; if (stable !== 1'b1) $display("FAIL bp_stable: got %b expected 1", stable); else pass_cnt++;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_out_valid_after: got %b expected 0", out_valid); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_after: got %b expected 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_reset_in_shift;
      int lat; bit rl; bit seen;
      issue(4'b0111, 32'h1234_5678, 32'd20);
      repeat (9) @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rs_mid_out_valid: got %b expected 0", out_valid); else pass_cnt++;
      reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rs_out_valid: got %b expected 0", out_valid); else pass_cnt++;
      total_cnt++; if (ALUResult !== 32'h0) $display("FAIL rs_result: got %h expected 00000000", ALUResult); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rs_in_ready: got %b expected 1", in_ready); else pass_cnt++;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      total_cnt++; if (seen !== 1'b0) $display("FAIL rs_stale_result: got %b expected 0", seen); else pass_cnt++;
      issue(4'b0000, 32'd2, 32'd3);
      wait_valid(lat, rl);
      total_cnt++; if (ALUResult !== 32'd5) $display("FAIL rs_next_op: got %h expected 00000005", ALUResult); else pass_cnt++;
      pop();
   endtask

   task automatic test_illegal_pass;
      int lat; bit rl;
      issue(4'b1010, 32'hAAAA_5555, 32'h1234);
      wait_valid(lat, rl);
      total_cnt++; if (illegal !== 1'b1) $display("FAIL ill_flag: got %b expected 1", illegal); else pass_cnt++;
      total_cnt++; if (ALUResult !== 32'h0) $display("FAIL ill_result: got %h expected 00000000", ALUResult); else pass_cnt++;
      total_cnt++; if (Zero !== 1'b1) $display("FAIL ill_zero: got %b expected 1", Zero); else pass_cnt++;
      total_cnt++; if (lat != 1) $display("FAIL ill_latency: got %0d expected 1", lat); else pass_cnt++;
      pop();
      issue(4'b1111, 32'hFFFF_FFFF, 32'h1234_5000);
      wait_valid(lat, rl);
      total_cnt++; if (ALUResult !== 32'h1234_5000) $display("FAIL pass_result: got %h expected 12345000", ALUResult); else pass_cnt++;
      total_cnt++; if (illegal !== 1'b0) $display("FAIL pass_illegal: got %b expected 0", illegal); else pass_cnt++;
      pop();
   endtask

   initial begin
      reset      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      ALUControl = 4'b0000;
      SrcA       = '0;
      SrcB       = '0;
      repeat (2) @(posedge clk);
      test_reset();
      test_add();
      test_sub_slt();
      test_shifts();
      test_ignore_inputs();
      test_backpressure();
      test_reset_in_shift();
      test_illegal_pass();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
